// File: rtl/usbh_nes_pad_serializer.sv
// usbh_nes_pad_serializer
// Emulates a 4021-based NES controller on the console port pins. The LATCH and
// CLK pins are synchronized and glitch-filtered, then the decoded button state
// is parallel-loaded and shifted out in NES order on the active-low DATA pin.
//
// Build option: define NES_PAD_DPAD_FILTER_EN to cancel opposing D-pad
// directions (Up+Down, Left+Right) in the value loaded into the shift register.
module usbh_nes_pad_serializer #(
  parameter int unsigned c_sync_stages = 2,  // min 2
  parameter int unsigned c_filter      = 2   // min 1, 1 = no filtering
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_btn,
  input  logic       i_latch,
  input  logic       i_pclk,
  output logic       o_data_n,
  output logic [3:0] o_bits,
  output logic       o_frame
);

  localparam int unsigned c_cnt_w = (c_filter > 1) ? $clog2(c_filter) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_filter - 1);
  localparam logic [3:0] c_bits_max = 4'd8;

  // Synchronizer chains, sampled output is the last stage
  logic [c_sync_stages-1:0] r_latch_sync;
  logic [c_sync_stages-1:0] r_pclk_sync;
  logic                     w_latch_s;
  logic                     w_pclk_s;

  // Filtered levels and their qualification counters
  logic               r_latch_flt;
  logic               r_pclk_flt;
  logic [c_cnt_w-1:0] r_latch_cnt;
  logic [c_cnt_w-1:0] r_pclk_cnt;
  logic               w_latch_flt_nxt;
  logic               w_pclk_flt_nxt;
  logic [c_cnt_w-1:0] w_latch_cnt_nxt;
  logic [c_cnt_w-1:0] w_pclk_cnt_nxt;

  // Previous filtered levels for edge detection
  logic r_latch_prev;
  logic r_pclk_prev;
  logic w_latch_fall;
  logic w_pclk_rise;

  // Shift register (1 = pressed) and shift counter
  logic [7:0] r_sreg;
  logic [3:0] r_bits;
  logic [7:0] w_sreg_nxt;
  logic [3:0] w_bits_nxt;
  logic [7:0] w_load_val;

  assign w_latch_s = r_latch_sync[c_sync_stages-1];
  assign w_pclk_s  = r_pclk_sync[c_sync_stages-1];

  // Plain flop chains; reset values match the idle pin levels
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_latch_sync <= '0;
      r_pclk_sync  <= '1;
    end else begin
      r_latch_sync <= {r_latch_sync[c_sync_stages-2:0], i_latch};
      r_pclk_sync  <= {r_pclk_sync[c_sync_stages-2:0], i_pclk};
    end
  end

  // LATCH filter: accept a new level after c_filter consecutive differing samples
  always_comb begin
    w_latch_flt_nxt = r_latch_flt;
    w_latch_cnt_nxt = '0;
    if (w_latch_s != r_latch_flt) begin
      if (r_latch_cnt == c_cnt_max) begin
        w_latch_flt_nxt = ~r_latch_flt;
      end else begin
        w_latch_cnt_nxt = r_latch_cnt + c_cnt_w'(1);
      end
    end
  end

  // CLK filter: same rule as LATCH
  always_comb begin
    w_pclk_flt_nxt = r_pclk_flt;
    w_pclk_cnt_nxt = '0;
    if (w_pclk_s != r_pclk_flt) begin
      if (r_pclk_cnt == c_cnt_max) begin
        w_pclk_flt_nxt = ~r_pclk_flt;
      end else begin
        w_pclk_cnt_nxt = r_pclk_cnt + c_cnt_w'(1);
      end
    end
  end

  // Filter state registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_latch_flt <= 1'b0;
      r_pclk_flt  <= 1'b1;
      r_latch_cnt <= '0;
      r_pclk_cnt  <= '0;
    end else begin
      r_latch_flt <= w_latch_flt_nxt;
      r_pclk_flt  <= w_pclk_flt_nxt;
      r_latch_cnt <= w_latch_cnt_nxt;
      r_pclk_cnt  <= w_pclk_cnt_nxt;
    end
  end

  // Edge history of the filtered levels
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_latch_prev <= 1'b0;
      r_pclk_prev  <= 1'b1;
    end else begin
      r_latch_prev <= r_latch_flt;
      r_pclk_prev  <= r_pclk_flt;
    end
  end

  assign w_latch_fall = r_latch_prev & ~r_latch_flt;
  assign w_pclk_rise  = ~r_pclk_prev & r_pclk_flt;

  // Value presented to the parallel load
  always_comb begin
    w_load_val = i_btn;
`ifdef NES_PAD_DPAD_FILTER_EN
    if (i_btn[4] && i_btn[5]) begin
      w_load_val[4] = 1'b0;
      w_load_val[5] = 1'b0;
    end
    if (i_btn[6] && i_btn[7]) begin
      w_load_val[6] = 1'b0;
      w_load_val[7] = 1'b0;
    end
`endif
  end

  // Load while LATCH is high (CLK ignored), otherwise shift on each CLK rise.
  // Fill with 1 so reads past bit 8 return "pressed" like a real pad.
  always_comb begin
    w_sreg_nxt = r_sreg;
    w_bits_nxt = r_bits;
    if (r_latch_flt) begin
      w_sreg_nxt = w_load_val;
      w_bits_nxt = '0;
    end else if (w_pclk_rise) begin
      w_sreg_nxt = {1'b1, r_sreg[7:1]};
      if (r_bits != c_bits_max) begin
        w_bits_nxt = r_bits + 4'd1;
      end
    end
  end

  // Shift state and registered port outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sreg   <= 8'h00;
      r_bits   <= '0;
      o_data_n <= 1'b1;
      o_frame  <= 1'b0;
    end else begin
      r_sreg   <= w_sreg_nxt;
      r_bits   <= w_bits_nxt;
      o_data_n <= ~r_sreg[0];
      o_frame  <= w_latch_fall;
    end
  end

  assign o_bits = r_bits;

endmodule
